// File: rtl/mem_access_sequencer_pkg.sv
// Shared encodings and helpers for the load/store sequencer: access sizes,
// FSM state codes, alignment rule and byte-enable generation.
package mem_access_sequencer_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Encoding 2'b11 falls through to the word rules everywhere.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    if (size == SZ_BYTE) return 1'b1;
    if (size == SZ_HALF) return ~off[0];
    return off == 2'b00;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_word(input logic [1:0] size);
    return (size == SZ_WORD) || (size == 2'b11);
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Single-port data bus seen by the sequencer: request/ack handshake plus
// word-aligned address, byte enables and data in both directions.
interface mem_access_sequencer_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_sequencer_lane_align.sv
// Combinational byte-lane steering: store side builds enables and replicated
// write data, load side extracts and extends the addressed bytes.
module mem_access_sequencer_lane_align
  import mem_access_sequencer_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] store_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        sign_ext_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ldata_o
);

  logic [3:0][7:0]  wlane;
  logic [3:0][7:0]  rbyte;
  logic [1:0][15:0] rhalf;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;

  assign be_o = byte_enables(st_size_i, st_off_i);

  // Each lane carries the low byte/half of the source so the enables pick the slot.
  for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
    assign wlane[gi] = (st_size_i == SZ_BYTE) ? store_data_i[7:0] :
                       (st_size_i == SZ_HALF) ? store_data_i[8*(gi%2) +: 8] :
                                                store_data_i[8*gi +: 8];
  end
  assign wdata_o = wlane;

  assign rbyte    = rdata_i;
  assign rhalf    = rdata_i;
  assign sel_byte = rbyte[ld_off_i];
  assign sel_half = rhalf[ld_off_i[1]];

  always_comb begin
    ldata_o = rdata_i;
    if (!is_word(ld_size_i)) begin
      if (ld_size_i == SZ_BYTE)
        ldata_o = {{24{sign_ext_i & sel_byte[7]}}, sel_byte};
      else
        ldata_o = {{16{sign_ext_i & sel_half[15]}}, sel_half};
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Load/store sequencer between the ALU state stage and a req/ack data bus:
// accepts one aligned op at a time, stalls upstream, returns aligned load data.
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic        load,
  input  logic        store,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] mem_address,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  mem_access_sequencer_if.master bus,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        exc_misalign,
  output logic        exc_timeout
);

  state_e          state_q, state_d;
  logic [29:0]     addr_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic            we_q;
  logic [4:0]      rd_q;
  logic [1:0]      size_q;
  logic [1:0]      off_q;
  logic            sext_q;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            kill_q, kill_d;
  logic            wb_pend_q, wb_pend_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            exc_mis_q, exc_mis_d;
  logic            exc_to_q, exc_to_d;

  logic            candidate;
  logic            aligned;
  logic            accept;
  logic            busy;
  logic            ack;
  logic            timed_out;
  logic [3:0]      st_be;
  logic [31:0]     st_wdata;
  logic [31:0]     ld_data;

  assign candidate = (state_q == ST_IDLE) & issue_valid & (load ^ store) & ~flush;
  assign aligned   = is_aligned(size, mem_address[1:0]);
  assign accept    = candidate & aligned;
  assign busy      = (state_q == ST_BUSY);
  assign ack       = bus.bus_ack;
  // An ack arriving on the last allowed cycle still completes the transfer.
  assign timed_out = busy & ~ack & (cnt_q == TO_W'(TIMEOUT));

  mem_access_sequencer_lane_align u_align (
    .st_size_i    (size),
    .st_off_i     (mem_address[1:0]),
    .store_data_i (store_data),
    .be_o         (st_be),
    .wdata_o      (st_wdata),
    .ld_size_i    (size_q),
    .ld_off_i     (off_q),
    .sign_ext_i   (sext_q),
    .rdata_i      (bus.bus_rdata),
    .ldata_o      (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (ack || timed_out) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.bus_req = busy;
    stall       = accept | busy;
    wb_valid    = (state_q == ST_RESP) & wb_pend_q & ~flush;
  end

  assign bus.bus_addr  = {addr_q, 2'b00};
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_we    = we_q;
  assign wb_data       = wb_data_q;
  assign wb_rd         = wb_rd_q;
  assign exc_misalign  = exc_mis_q;
  assign exc_timeout   = exc_to_q;

  // Flush during BUSY cannot abort the bus cycle, so it is remembered in kill_q.
  always_comb begin
    cnt_d     = cnt_q;
    kill_d    = kill_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    if (accept) begin
      cnt_d  = '0;
      kill_d = 1'b0;
    end else if (busy) begin
      if (cnt_q != {TO_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      if (flush) kill_d = 1'b1;
    end
    wb_pend_d = busy & ack & ~we_q & ~kill_q & ~flush;
    if (busy && ack && !we_q) begin
      wb_data_d = ld_data;
      wb_rd_d   = rd_q;
    end
    exc_mis_d = candidate & ~aligned;
    exc_to_d  = timed_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      size_q    <= '0;
      off_q     <= '0;
      sext_q    <= 1'b0;
      cnt_q     <= '0;
      kill_q    <= 1'b0;
      wb_pend_q <= 1'b0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      exc_mis_q <= 1'b0;
      exc_to_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= mem_address[31:2];
        be_q    <= st_be;
        wdata_q <= st_wdata;
        we_q    <= store;
        rd_q    <= rd_in;
        size_q  <= size;
        off_q   <= mem_address[1:0];
        sext_q  <= sign_ext;
      end
      cnt_q     <= cnt_d;
      kill_q    <= kill_d;
      wb_pend_q <= wb_pend_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      exc_mis_q <= exc_mis_d;
      exc_to_q  <= exc_to_d;
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: directed scenarios followed by
// random ops checked against a byte-arithmetic reference model.
module tb_mem_access_sequencer;

  localparam int TIMEOUT  = 4;
  // The wait counter reads 0 in the first BUSY cycle, so BUSY lasts at most TIMEOUT+1 cycles.
  localparam int MAX_BUSY = TIMEOUT + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0, load = 1'b0, store = 1'b0, sign_ext = 1'b0, flush = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] mem_address = '0, store_data = '0;
  logic [4:0]  rd_in = '0;
  logic        stall, wb_valid, exc_misalign, exc_timeout;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  int errors = 0;
  int checks = 0;

  mem_access_sequencer_if bus_if ();

  always #5 clk = ~clk;

  mem_access_sequencer #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .load(load), .store(store),
    .size(size), .sign_ext(sign_ext), .mem_address(mem_address), .store_data(store_data),
    .rd_in(rd_in), .flush(flush), .bus(bus_if), .stall(stall), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd(wb_rd), .exc_misalign(exc_misalign), .exc_timeout(exc_timeout)
  );

  // Observations gathered by do_op for one transaction.
  logic        o_stall0, o_stable, o_we, o_done;
  int          o_stall_n, o_req_n, o_wb_n, o_wb_cyc, o_mis_n, o_mis_cyc, o_to_n, o_to_cyc;
  logic [31:0] o_addr, o_wdata, o_wb_data;
  logic [3:0]  o_be;
  logic [4:0]  o_wb_rd;

  // ---------------- reference model ----------------
  function automatic int m_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_aligned(input logic [1:0] sz, input logic [31:0] a);
    return (a % m_bytes(sz)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int mask = (1 << m_bytes(sz)) - 1;
    return 4'(mask << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] sd);
    if (sz == 2'd0) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sx, input logic [31:0] a,
                                         input logic [31:0] rv);
    logic [31:0] v;
    v = rv >> (8 * (a % 4));
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // ---------------- stimulus driver (observes, does not judge) ----------------
  task automatic do_op(input logic ld, input logic st, input logic [1:0] sz, input logic sx,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdv,
                       input logic [4:0] rd, input int ack_at, input int flush_at);
    int busy_n;
    busy_n = 0;
    o_stall0 = 0; o_stable = 1; o_we = 0; o_done = 0;
    o_stall_n = 0; o_req_n = 0; o_wb_n = 0; o_wb_cyc = -1; o_mis_n = 0; o_mis_cyc = -1;
    o_to_n = 0; o_to_cyc = -1; o_addr = '0; o_wdata = '0; o_wb_data = '0; o_be = '0; o_wb_rd = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      issue_valid = (c == 0);
      load = ld; store = st; size = sz; sign_ext = sx;
      mem_address = addr; store_data = sd; rd_in = rd;
      flush = (c == flush_at);
      bus_if.bus_ack = 1'b0;
      bus_if.bus_rdata = $urandom();
      if (bus_if.bus_req === 1'b1) begin
        busy_n++;
        o_req_n++;
        if (busy_n == ack_at) begin
          bus_if.bus_ack = 1'b1;
          bus_if.bus_rdata = rdv;
        end
        if (busy_n == 1) begin
          o_addr = bus_if.bus_addr; o_be = bus_if.bus_be;
          o_wdata = bus_if.bus_wdata; o_we = bus_if.bus_we;
        end else if (o_addr !== bus_if.bus_addr || o_be !== bus_if.bus_be ||
                     o_wdata !== bus_if.bus_wdata || o_we !== bus_if.bus_we) begin
          o_stable = 0;
        end
      end
      #1;
      if (c == 0) o_stall0 = (stall === 1'b1);
      if (stall === 1'b1) o_stall_n++;
      if (wb_valid === 1'b1) begin
        o_wb_n++; o_wb_cyc = c; o_wb_data = wb_data; o_wb_rd = wb_rd;
      end
      if (exc_misalign === 1'b1) begin o_mis_n++; o_mis_cyc = c; end
      if (exc_timeout === 1'b1) begin o_to_n++; o_to_cyc = c; end
      if (c >= 1 && stall !== 1'b1 && bus_if.bus_req !== 1'b1) begin
        o_done = 1;
        break;
      end
    end
    issue_valid = 1'b0; flush = 1'b0; bus_if.bus_ack = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata,
         stall, wb_valid, wb_data, wb_rd, exc_misalign, exc_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wdata=%h stall=%b wbv=%b wbd=%h rd=%h mis=%b to=%b want all 0",
               bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata,
               stall, wb_valid, wb_data, wb_rd, exc_misalign, exc_timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({bus_if.bus_req, stall} !== 2'b00) begin
      errors++; $display("FAIL idle_after_reset: got req/stall=%b want 00", {bus_if.bus_req, stall});
    end
  endtask

  task automatic test_load_word;
    do_op(1, 0, 2'd2, 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 5'd9, 3, -1);
    checks++; if (o_be !== 4'b1111) begin errors++; $display("FAIL lw_be: got %b want 1111", o_be); end
    checks++; if (o_addr !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h want 00000100", o_addr); end
    checks++; if (o_stall_n != 4) begin errors++; $display("FAIL lw_stall_cycles: got %0d want 4", o_stall_n); end
    checks++; if (o_wb_n != 1 || o_wb_cyc != 4) begin
      errors++; $display("FAIL lw_wb_valid: got count=%0d cycle=%0d want 1 at 4", o_wb_n, o_wb_cyc); end
    checks++; if (o_wb_data !== 32'hDEAD_BEEF || o_wb_rd !== 5'd9) begin
      errors++; $display("FAIL lw_wb_data: got %h rd=%0d want deadbeef rd=9", o_wb_data, o_wb_rd); end
  endtask

  task automatic test_load_byte;
    do_op(1, 0, 2'd0, 1, 32'h0000_0103, 32'h0, 32'h8011_2233, 5'd5, 1, -1);
    checks++; if (o_be !== 4'b1000) begin errors++; $display("FAIL lb_be: got %b want 1000", o_be); end
    checks++; if (o_wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", o_wb_data); end
    checks++; if (o_stall_n != 2 || o_wb_cyc != 2) begin
      errors++; $display("FAIL lb_min_latency: got stall=%0d wb_cycle=%0d want 2 and 2", o_stall_n, o_wb_cyc); end
    do_op(1, 0, 2'd0, 0, 32'h0000_0103, 32'h0, 32'h8011_2233, 5'd6, 2, -1);
    checks++; if (o_wb_n != 1 || o_wb_data !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu_data: got count=%0d data=%h want 1 00000080", o_wb_n, o_wb_data); end
  endtask

  task automatic test_store_half;
    do_op(0, 1, 2'd1, 0, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 5'd1, 2, -1);
    checks++; if (o_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b want 1100", o_be); end
    checks++; if (o_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h want abcdabcd", o_wdata); end
    checks++; if (o_we !== 1'b1 || o_addr !== 32'h200) begin
      errors++; $display("FAIL sh_we_addr: got we=%b addr=%h want 1 00000200", o_we, o_addr); end
    checks++; if (o_wb_n != 0) begin errors++; $display("FAIL sh_no_wb: got %0d want 0", o_wb_n); end
  endtask

  task automatic test_misalign;
    do_op(1, 0, 2'd2, 0, 32'h0000_0101, 32'h0, 32'h0, 5'd2, 1, -1);
    checks++; if (o_mis_n != 1 || o_mis_cyc != 1) begin
      errors++; $display("FAIL misalign_pulse: got count=%0d cycle=%0d want 1 at 1", o_mis_n, o_mis_cyc); end
    checks++; if (o_req_n != 0 || o_stall_n != 0) begin
      errors++; $display("FAIL misalign_no_bus: got req=%0d stall=%0d want 0 0", o_req_n, o_stall_n); end
    do_op(1, 1, 2'd2, 0, 32'h0000_0101, 32'h0, 32'h0, 5'd2, 1, -1);
    checks++; if (o_mis_n != 0 || o_stall_n != 0 || o_req_n != 0) begin
      errors++; $display("FAIL both_ops_ignored: got mis=%0d stall=%0d req=%0d want 0 0 0", o_mis_n, o_stall_n, o_req_n); end
  endtask

  task automatic test_flush;
    do_op(1, 0, 2'd2, 0, 32'h0000_0400, 32'h0, 32'h1234_5678, 5'd7, 4, 2);
    checks++; if (o_req_n != 4 || !o_stable) begin
      errors++; $display("FAIL flush_busy_completes: got req=%0d stable=%b want 4 1", o_req_n, o_stable); end
    checks++; if (o_wb_n != 0) begin errors++; $display("FAIL flush_busy_wb: got %0d want 0", o_wb_n); end
    do_op(1, 0, 2'd2, 0, 32'h0000_0400, 32'h0, 32'h1234_5678, 5'd7, 1, 0);
    checks++; if (o_stall0 || o_req_n != 0) begin
      errors++; $display("FAIL flush_at_accept: got stall0=%b req=%0d want 0 0", o_stall0, o_req_n); end
  endtask

  task automatic test_timeout;
    do_op(1, 0, 2'd2, 0, 32'h0000_0300, 32'h0, 32'h1111_2222, 5'd3, 0, -1);
    checks++; if (o_to_n != 1 || o_to_cyc != MAX_BUSY + 1) begin
      errors++; $display("FAIL timeout_pulse: got count=%0d cycle=%0d want 1 at %0d", o_to_n, o_to_cyc, MAX_BUSY + 1); end
    checks++; if (o_req_n != MAX_BUSY || o_wb_n != 0) begin
      errors++; $display("FAIL timeout_req_wb: got req=%0d wb=%0d want %0d 0", o_req_n, o_wb_n, MAX_BUSY); end
    // Issued in the cycle right after RESP; ack lands on the last allowed BUSY cycle.
    do_op(1, 0, 2'd2, 0, 32'h0000_0304, 32'h0, 32'h5555_AAAA, 5'd4, MAX_BUSY, -1);
    checks++; if (!o_stall0) begin errors++; $display("FAIL back_to_back_accept: got stall0=0 want 1"); end
    checks++; if (o_to_n != 0 || o_wb_n != 1 || o_wb_data !== 32'h5555_AAAA) begin
      errors++; $display("FAIL ack_wins_timeout: got to=%0d wb=%0d data=%h want 0 1 5555aaaa", o_to_n, o_wb_n, o_wb_data); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    issue_valid = 1; load = 0; store = 1; size = 2'd2; mem_address = 32'h0000_0440;
    store_data = 32'hCAFE_F00D; flush = 0; bus_if.bus_ack = 0;
    @(negedge clk); issue_valid = 0;
    @(negedge clk); #1;
    checks++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_we !== 1'b1) begin
      errors++; $display("FAIL mid_busy_req: got req=%b we=%b want 1 1", bus_if.bus_req, bus_if.bus_we); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata, stall} !== '0) begin
      errors++;
      $display("FAIL async_reset_bus: got req=%b we=%b addr=%h be=%b wdata=%h stall=%b want all 0",
               bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata, stall);
    end
    @(negedge clk); rst_n = 1'b1;
    do_op(1, 0, 2'd2, 0, 32'h0000_0500, 32'h0, 32'h0BAD_F00D, 5'd8, 1, -1);
    checks++; if (!o_stall0 || o_wb_data !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL after_reset_op: got stall0=%b data=%h want 1 0badf00d", o_stall0, o_wb_data); end
  endtask

  task automatic test_random(input int n);
    logic        ld, st, sx, cand, acc, acked, killed, want_wb, coin;
    logic [1:0]  sz;
    logic [31:0] a, sd, rv;
    logic [4:0]  rd;
    int          kind, ack_at, flush_at, busy_c;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 9);
      coin = 1'($urandom_range(0, 1));
      ld = (kind <= 4) || (kind == 9 && coin);
      st = (kind >= 5 && kind <= 8) || (kind == 9 && coin);
      sz = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      a = $urandom();
      if ($urandom_range(0, 9) < 7) a[1:0] = 2'b00;
      sd = $urandom(); rv = $urandom(); rd = 5'($urandom_range(0, 31));
      ack_at = $urandom_range(0, MAX_BUSY + 1);
      flush_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4) : -1;

      cand    = (ld ^ st) && (flush_at != 0);
      acc     = cand && m_aligned(sz, a);
      acked   = (ack_at >= 1) && (ack_at <= MAX_BUSY);
      busy_c  = acked ? ack_at : MAX_BUSY;
      killed  = (flush_at >= 1) && (flush_at <= busy_c + 1);
      want_wb = acc && ld && acked && !killed;

      do_op(ld, st, sz, sx, a, sd, rv, rd, ack_at, flush_at);

      checks++; if (!o_done) begin errors++; $display("FAIL rnd%0d_bounded: op did not return to idle", i); end
      checks++; if (o_stall0 !== acc || o_stall_n != (acc ? busy_c + 1 : 0)) begin
        errors++; $display("FAIL rnd%0d_stall: got first=%b cycles=%0d want %b %0d", i, o_stall0, o_stall_n, acc, acc ? busy_c + 1 : 0); end
      checks++; if (o_req_n != (acc ? busy_c : 0)) begin
        errors++; $display("FAIL rnd%0d_req: got %0d want %0d", i, o_req_n, acc ? busy_c : 0); end
      checks++; if (o_mis_n != ((cand && !acc) ? 1 : 0)) begin
        errors++; $display("FAIL rnd%0d_misalign: got %0d want %0d", i, o_mis_n, (cand && !acc) ? 1 : 0); end
      checks++; if (o_to_n != ((acc && !acked) ? 1 : 0)) begin
        errors++; $display("FAIL rnd%0d_timeout: got %0d want %0d", i, o_to_n, (acc && !acked) ? 1 : 0); end
      checks++; if (o_wb_n != (want_wb ? 1 : 0)) begin
        errors++; $display("FAIL rnd%0d_wb_valid: got %0d want %0d", i, o_wb_n, want_wb ? 1 : 0); end
      if (acc) begin
        checks++;
        if (o_addr !== {a[31:2], 2'b00} || o_be !== m_be(sz, a) || o_we !== st || !o_stable) begin
          errors++; $display("FAIL rnd%0d_bus: got addr=%h be=%b we=%b stable=%b want %h %b %b 1",
                             i, o_addr, o_be, o_we, o_stable, {a[31:2], 2'b00}, m_be(sz, a), st);
        end
      end
      if (acc && st) begin
        checks++; if (o_wdata !== m_wdata(sz, sd)) begin
          errors++; $display("FAIL rnd%0d_wdata: got %h want %h", i, o_wdata, m_wdata(sz, sd)); end
      end
      if (want_wb) begin
        checks++;
        if (o_wb_data !== m_load(sz, sx, a, rv) || o_wb_rd !== rd || o_wb_cyc != busy_c + 1) begin
          errors++; $display("FAIL rnd%0d_wb_data: got %h rd=%0d cyc=%0d want %h rd=%0d cyc=%0d",
                             i, o_wb_data, o_wb_rd, o_wb_cyc, m_load(sz, sx, a, rv), rd, busy_c + 1);
        end
      end
    end
  endtask

  initial begin
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = '0;
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_random(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t want under 200000", $time);
    $fatal(1);
  end

endmodule
